lsu_data_mem: RTL and testbench

Parametrised data memory with a load/store access unit. It is the next-generation replacement for the single-cycle data memory stage. It adds a valid/ready request and response handshake, configurable access latency, byte/half/word accesses with sign or zero extension, and error reporting for misaligned or out-of-range addresses. It sits between execute and writeback, and lets the core stall on memory.

---
 rtl/lsu_data_mem_pkg.sv | 19 +
 rtl/lsu_data_mem_if.sv | 29 ++
 rtl/lsu_data_mem_lane_align.sv | 43 ++++
 rtl/lsu_data_mem.sv | 147 ++++++++++++++
 tb/tb_lsu_data_mem.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_data_mem_pkg.sv
// Shared encodings for the load/store data memory: access sizes, FSM states, lane count.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'd0;
    localparam logic [1:0] SZ_HALF    = 2'd1;
    localparam logic [1:0] SZ_WORD    = 2'd2;
    localparam logic [1:0] SZ_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/lsu_data_mem_if.sv
// Request/response bus between the core's execute stage and the load/store data memory.
// Handshake: a beat transfers on a rising edge where valid & ready are both high; the
// sender holds valid and its payload stable until that edge, and ready never waits on valid.
interface lsu_data_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_data_mem_lane_align.sv
// Byte-lane steering: extracts and extends load data, and replicates store data
// across lanes together with the byte-enable mask for the addressed lanes.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   word,
    input  logic [1:0]          offset,
    input  logic [1:0]          size,
    input  logic                is_unsigned,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   load_data,
    output logic [DATA_W-1:0]   store_word,
    output logic [DATA_W/8-1:0] byte_en
);
    localparam int LANES = lane_count(DATA_W);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = word[{offset[1], 4'b0000} +: 16];

    always_comb begin
        load_data  = word;
        store_word = wdata;
        byte_en    = '1;
        case (size)
            SZ_BYTE: begin
                load_data  = {{(DATA_W-8){~is_unsigned & lane_b[7]}}, lane_b};
                store_word = {LANES{wdata[7:0]}};
                byte_en    = LANES'(1) << offset;
            end
            SZ_HALF: begin
                load_data  = {{(DATA_W-16){~is_unsigned & lane_h[15]}}, lane_h};
                store_word = {(LANES/2){wdata[15:0]}};
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_data_mem.sv
// Data memory with a valid/ready load/store unit: programmable access latency,
// byte/half/word accesses with extension, and alignment/range fault reporting.
module lsu_data_mem
    import mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 128,
    parameter int LATENCY    = 1,
    parameter int INIT_INDEX = 1
) (
    input  logic             clk,
    input  logic             rst,
    lsu_data_mem_if.slave    bus,
    output state_t           dbg_state
);
    localparam int         LANES    = lane_count(DATA_W);
    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic       ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_M1   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    // Words hold the difference from the power-up image, so an all-zero
    // power-up state reads back as the configured initial contents.
    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    logic              idle, accept, commit;
    logic              acc_write, acc_uns, acc_err;
    logic [1:0]        acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] img_word, cur_word, load_data, store_word;
    logic [LANES-1:0]  byte_en;

    function automatic logic [DATA_W-1:0] image(input logic [IDX_W-1:0] i);
        return (INIT_INDEX != 0) ? DATA_W'(i) : '0;
    endfunction

    assign idle          = (state_q == ST_IDLE);
    assign bus.req_ready = rst & idle;
    assign accept        = bus.req_valid & bus.req_ready;

    // With zero latency the access commits on the accept edge from the live request.
    assign acc_write = idle ? bus.req_write    : wr_q;
    assign acc_size  = idle ? bus.req_size     : size_q;
    assign acc_uns   = idle ? bus.req_unsigned : uns_q;
    assign acc_addr  = idle ? bus.req_addr     : addr_q;
    assign acc_wdata = idle ? bus.req_wdata    : wdata_q;

    assign commit = ZERO_LAT ? accept : (state_q == ST_BUSY && cnt_q == 4'd0);

    assign acc_err = (acc_size == SZ_ILLEGAL)
                   | (acc_size == SZ_HALF & acc_addr[0])
                   | (acc_size == SZ_WORD & (acc_addr[1:0] != 2'b00))
                   | (acc_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

    assign idx      = acc_addr[IDX_W+1:2];
    assign img_word = image(idx);
    assign cur_word = mem_q[idx] ^ img_word;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .word        (cur_word),
        .offset      (acc_addr[1:0]),
        .size        (acc_size),
        .is_unsigned (acc_uns),
        .wdata       (acc_wdata),
        .load_data   (load_data),
        .store_word  (store_word),
        .byte_en     (byte_en)
    );

    always_ff @(posedge clk) begin
        if (commit && acc_write && !acc_err) begin
            for (int l = 0; l < LANES; l++) begin
                if (byte_en[l]) mem_q[idx][8*l +: 8] <= store_word[8*l +: 8] ^ img_word[8*l +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= bus.req_write;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err | acc_write) ? '0 : load_data;
            end else if (state_q == ST_RESP && bus.resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ZERO_LAT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                if (bus.resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: three instances (latency 2, 4 and 0) share one
// stimulus bus; sel picks which instance sees req_valid and whose outputs are observed.
module tb_lsu_data_mem;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          sel = 2;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = SZ_WORD;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;

    logic        o_req_ready, o_resp_valid, o_err;
    logic [31:0] o_rdata;
    state_t      o_state, st0, st2, st4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_data_mem_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    lsu_data_mem_if #(.ADDR_W(32), .DATA_W(32)) if2 ();
    lsu_data_mem_if #(.ADDR_W(32), .DATA_W(32)) if4 ();

    assign if0.req_valid = req_valid && (sel == 0);
    assign if2.req_valid = req_valid && (sel == 2);
    assign if4.req_valid = req_valid && (sel == 4);
    assign {if0.req_write, if2.req_write, if4.req_write} = {3{req_write}};
    assign {if0.req_size, if2.req_size, if4.req_size} = {3{req_size}};
    assign {if0.req_unsigned, if2.req_unsigned, if4.req_unsigned} = {3{req_unsigned}};
    assign {if0.req_addr, if2.req_addr, if4.req_addr} = {3{req_addr}};
    assign {if0.req_wdata, if2.req_wdata, if4.req_wdata} = {3{req_wdata}};
    assign {if0.resp_ready, if2.resp_ready, if4.resp_ready} = {3{resp_ready}};

    lsu_data_mem #(.LATENCY(0)) u_l0 (.clk(clk), .rst(rst), .bus(if0.slave), .dbg_state(st0));
    lsu_data_mem #(.LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .bus(if2.slave), .dbg_state(st2));
    lsu_data_mem #(.LATENCY(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4.slave), .dbg_state(st4));

    always_comb begin
        o_req_ready  = if2.req_ready;
        o_resp_valid = if2.resp_valid;
        o_rdata      = if2.resp_rdata;
        o_err        = if2.resp_err;
        o_state      = st2;
        case (sel)
            0: begin
                o_req_ready = if0.req_ready; o_resp_valid = if0.resp_valid;
                o_rdata = if0.resp_rdata; o_err = if0.resp_err; o_state = st0;
            end
            4: begin
                o_req_ready = if4.req_ready; o_resp_valid = if4.resp_valid;
                o_rdata = if4.resp_rdata; o_err = if4.resp_err; o_state = st4;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and waits (bounded) for the response to appear.
    task automatic issue_wait(input string tag, input int s, input logic w, input logic [1:0] sz,
                              input logic u, input logic [31:0] a, input logic [31:0] d,
                              input int lat, output logic [31:0] rd, output logic er);
        int n;
        sel = s;
        check({tag, "_ready_before"}, o_req_ready, 1'b1);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (!o_resp_valid && n < 64) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, lat + 1);
        rd = o_rdata;
        er = o_err;
    endtask

    task automatic complete(input string tag);
        resp_ready = 1'b1;
        tick();
        check({tag, "_valid_after"}, o_resp_valid, 1'b0);
        check({tag, "_ready_after"}, o_req_ready, 1'b1);
        check({tag, "_rdata_after"}, o_rdata, 32'h0);
        check({tag, "_err_after"}, o_err, 1'b0);
    endtask

    task automatic run(input string tag, input int s, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input int lat, input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        resp_ready = 1'b1;
        issue_wait(tag, s, w, sz, u, a, d, lat, rd, er);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, er, exp_err);
        complete(tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        repeat (2) tick();
        check("rst_req_ready", o_req_ready, 1'b0);
        check("rst_resp_valid", o_resp_valid, 1'b0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_err", o_err, 1'b0);
        check("rst_state", 32'(o_state), 32'(ST_IDLE));
        rst = 1'b1;
        #1;
        check("release_req_ready", o_req_ready, 1'b1);
        tick();

        run("lw8",    2, 1'b0, SZ_WORD, 1'b0, 32'h8,  32'h0,        2, 32'h0000_0002, 1'b0);
        run("sb11",   2, 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h0000_00AB, 2, 32'h0,         1'b0);
        run("lw10",   2, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0,        2, 32'h0000_AB04, 1'b0);
        run("lb11",   2, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0,        2, 32'hFFFF_FFAB, 1'b0);
        run("lbu11",  2, 1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0,        2, 32'h0000_00AB, 1'b0);
        run("sh22",   2, 1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0000_8001, 2, 32'h0,         1'b0);
        run("lw20",   2, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0,        2, 32'h8001_0008, 1'b0);
        run("lh22",   2, 1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0,        2, 32'hFFFF_8001, 1'b0);
        run("lhu22",  2, 1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0,        2, 32'h0000_8001, 1'b0);
        run("sb17",   2, 1'b1, SZ_BYTE, 1'b0, 32'h17, 32'hFFFF_FF80, 2, 32'h0,         1'b0);
        run("lw14",   2, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0,        2, 32'h8000_0005, 1'b0);
        run("lb17",   2, 1'b0, SZ_BYTE, 1'b0, 32'h17, 32'h0,        2, 32'hFFFF_FF80, 1'b0);
        run("lw6",    2, 1'b0, SZ_WORD, 1'b0, 32'h6,  32'h0,        2, 32'h0,         1'b1);
        run("lh21",   2, 1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0,        2, 32'h0,         1'b1);
        run("sw200",  2, 1'b1, SZ_WORD, 1'b0, 32'h200, 32'h1234_5678, 2, 32'h0,        1'b1);
        run("lw0",    2, 1'b0, SZ_WORD, 1'b0, 32'h0,  32'h0,        2, 32'h0,         1'b0);
        run("size3",  2, 1'b0, 2'd3,    1'b0, 32'h4,  32'h0,        2, 32'h0,         1'b1);
        run("lw1fc",  2, 1'b0, SZ_WORD, 1'b0, 32'h1FC, 32'h0,       2, 32'h0000_007F, 1'b0);

        // Backpressure: response held while resp_ready is low; a new request is ignored.
        resp_ready = 1'b0;
        issue_wait("bp", 2, 1'b0, SZ_WORD, 1'b0, 32'hC, 32'h0, 2, rd, er);
        check("bp_rdata", rd, 32'h0000_0003);
        req_write = 1'b0; req_size = SZ_WORD; req_addr = 32'h0;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", o_resp_valid, 1'b1);
            check("bp_hold_rdata", o_rdata, 32'h0000_0003);
            check("bp_hold_err", o_err, 1'b0);
            check("bp_hold_ready", o_req_ready, 1'b0);
        end
        req_valid = 1'b0;
        complete("bp");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_no_extra_resp", o_resp_valid, 1'b0);
            check("bp_state_idle", 32'(o_state), 32'(ST_IDLE));
        end

        // Reset while a store waits in BUSY: the store must never land.
        sel = 4;
        req_write = 1'b1; req_size = SZ_WORD; req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("l4_busy", 32'(o_state), 32'(ST_BUSY));
        rst = 1'b0;
        #1;
        check("l4_rst_valid", o_resp_valid, 1'b0);
        check("l4_rst_rdata", o_rdata, 32'h0);
        check("l4_rst_err", o_err, 1'b0);
        check("l4_rst_ready", o_req_ready, 1'b0);
        check("l4_rst_state", 32'(o_state), 32'(ST_IDLE));
        repeat (6) tick();
        rst = 1'b1;
        #1;
        run("l4_lw0", 4, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 4, 32'h0, 1'b0);
        run("l4_lw8", 4, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 4, 32'h2, 1'b0);

        // Zero latency: back-to-back loads, then a committed store survives reset.
        run("l0_lw4", 0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0, 0, 32'h1, 1'b0);
        run("l0_lw8", 0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 0, 32'h2, 1'b0);
        resp_ready = 1'b0;
        issue_wait("l0_sw30", 0, 1'b1, SZ_WORD, 1'b0, 32'h30, 32'hCAFE_F00D, 0, rd, er);
        check("l0_sw30_err", er, 1'b0);
        rst = 1'b0;
        #1;
        check("l0_rst_valid", o_resp_valid, 1'b0);
        check("l0_rst_ready", o_req_ready, 1'b0);
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;
        #1;
        run("l0_lw30", 0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        run("l0_lbu33", 0, 1'b0, SZ_BYTE, 1'b1, 32'h33, 32'h0, 0, 32'h0000_00CA, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
